// File: rtl/riscv_boot_ctrl.sv
// Boot/run controller: loads a little-endian image (32-bit word-count header then words)
// into imem while holding the core in reset, then runs the core until halt or timeout.
module riscv_boot_ctrl #(
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_reset,
  input  logic              core_halt,
  output logic              done,
  output logic              timeout,
  output logic              err,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned BPW   = DATA_W / 8;
  localparam int unsigned IDX_W = (BPW > 4) ? $clog2(BPW) : 2;
  localparam logic [32:0] LIMIT = 33'd1 << ADDR_W;

  // S_LAST is the write cycle of the final word; RUN begins on the following edge
  typedef enum logic [2:0] {S_HDR, S_LOAD, S_LAST, S_RUN, S_HALT, S_TMO, S_ERR} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_hdr;
  logic [DATA_W-1:0] r_word;
  logic              r_rx_ready;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [DATA_W-1:0] r_imem_wdata;
  logic              r_core_reset;
  logic              r_done;
  logic              r_timeout;
  logic              r_err;
  logic [CNT_W-1:0]  r_cycle;
  logic [ADDR_W:0]   r_words;

  logic              w_acc;
  logic              w_last;
  logic [31:0]       w_hdr;
  logic [DATA_W-1:0] w_word;

  assign w_acc  = rx_valid & r_rx_ready;
  assign w_last = (33'(r_words) + 33'd1) == {1'b0, r_hdr};

  always_comb begin
    w_hdr  = r_hdr;
    w_word = r_word;
    w_hdr[{r_idx[1:0], 3'b000} +: 8] = rx_data;
    w_word[{r_idx, 3'b000} +: 8]     = rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_HDR;
      r_idx        <= '0;
      r_hdr        <= '0;
      r_word       <= '0;
      r_rx_ready   <= 1'b1;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_err        <= 1'b0;
      r_cycle      <= '0;
      r_words      <= '0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        S_HDR: begin
          if (w_acc) begin
            r_hdr <= w_hdr;
            if (r_idx == IDX_W'(3)) begin
              r_idx <= '0;
              if (w_hdr == '0) begin
                r_state      <= S_RUN;
                r_rx_ready   <= 1'b0;
                r_core_reset <= 1'b0;
              end else if ({1'b0, w_hdr} > LIMIT) begin
                r_state    <= S_ERR;
                r_rx_ready <= 1'b0;
                r_err      <= 1'b1;
              end else begin
                r_state <= S_LOAD;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_acc) begin
            r_word <= w_word;
            if (r_idx == IDX_W'(BPW - 1)) begin
              r_idx        <= '0;
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_words[ADDR_W-1:0];
              r_imem_wdata <= w_word;
              r_words      <= r_words + 1'b1;
              if (w_last) begin
                r_state    <= S_LAST;
                r_rx_ready <= 1'b0;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_LAST: begin
          r_state      <= S_RUN;
          r_core_reset <= 1'b0;
        end
        S_RUN: begin
          r_cycle <= r_cycle + 1'b1;
          if (core_halt) begin
            r_state      <= S_HALT;
            r_done       <= 1'b1;
            r_core_reset <= 1'b1;
          end else if (r_cycle == CNT_W'(MAX_CYCLES - 1)) begin
            r_state      <= S_TMO;
            r_timeout    <= 1'b1;
            r_core_reset <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready     = r_rx_ready;
  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign core_reset   = r_core_reset;
  assign done         = r_done;
  assign timeout      = r_timeout;
  assign err          = r_err;
  assign cycle_count  = r_cycle;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Self-checking bench for riscv_boot_ctrl: byte-stream reference model checked every cycle,
// plus literal expectations for the directed load/halt/timeout/error scenarios.
module tb_riscv_boot_ctrl;
  localparam int AW = 4, DW = 32, CW = 32, MAXC = 16, BPW = DW / 8;

  logic          clk = 1'b0, reset = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0, core_halt = 1'b0;
  logic          rx_ready, imem_we, core_reset, done, timeout, err;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic [CW-1:0] cycle_count;
  logic [AW:0]   words_loaded;

  riscv_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .core_halt(core_halt), .done(done), .timeout(timeout),
    .err(err), .cycle_count(cycle_count), .words_loaded(words_loaded));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: everything derives from the list of accepted bytes and the RUN cycle count
  logic [7:0]    m_bytes[$];
  bit            m_we, m_done, m_tmo, m_err, m_rdy, m_crst, m_run, m_pend;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_words, m_cyc, n, k;
  longint        m_n;
  bit            was_run, was_pend;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_bytes.delete();
      m_we = 0; m_addr = '0; m_wdata = '0; m_words = 0; m_cyc = 0;
      m_done = 0; m_tmo = 0; m_err = 0; m_rdy = 1; m_crst = 1; m_run = 0; m_pend = 0;
      chk_en = 1;
    end else begin
      was_run = m_run; was_pend = m_pend;
      m_we = 0; m_pend = 0;
      if (rx_valid && m_rdy) begin
        m_bytes.push_back(rx_data);
        n = m_bytes.size();
        if (n == 4) begin
          m_n = longint'(m_bytes[0]) | (longint'(m_bytes[1]) << 8) |
                (longint'(m_bytes[2]) << 16) | (longint'(m_bytes[3]) << 24);
          if (m_n == 0) begin m_run = 1; m_crst = 0; m_rdy = 0; end
          else if (m_n > (longint'(1) << AW)) begin m_err = 1; m_rdy = 0; end
        end else if (n > 4 && (n - 4) % BPW == 0) begin
          k = (n - 4) / BPW - 1;
          m_wdata = '0;
          for (int j = 0; j < BPW; j++) m_wdata |= DW'(m_bytes[4 + k * BPW + j]) << (8 * j);
          m_we = 1; m_addr = AW'(k); m_words = k + 1;
          if (longint'(k + 1) == m_n) begin m_rdy = 0; m_pend = 1; end
        end
      end
      if (was_pend) begin m_run = 1; m_crst = 0; end
      if (was_run) begin
        m_cyc++;
        if (core_halt) begin m_done = 1; m_crst = 1; m_run = 0; end
        else if (m_cyc == MAXC) begin m_tmo = 1; m_crst = 1; m_run = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rx_ready", rx_ready, m_rdy);
      chk("imem_we", imem_we, m_we);
      chk("imem_addr", imem_addr, m_addr);
      chk("imem_wdata", imem_wdata, m_wdata);
      chk("core_reset", core_reset, m_crst);
      chk("done", done, m_done);
      chk("timeout", timeout, m_tmo);
      chk("err", err, m_err);
      chk("cycle_count", cycle_count, m_cyc);
      chk("words_loaded", words_loaded, m_words);
    end
  end

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } wr_t;
  wr_t        wr_q[$];
  logic [31:0] img_q[$];
  int  fall_cyc = -1;
  bit  prev_crst = 1;

  always @(negedge clk) begin
    if (chk_en) begin
      if (imem_we) wr_q.push_back('{imem_addr, imem_wdata, cyc});
      if (prev_crst && !core_reset) fall_cyc = cyc;
      prev_crst = core_reset;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; rx_valid = 0; core_halt = 0;
    tick(); tick();
    reset = 0; wr_q.delete(); fall_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmax);
    int g; bit ok;
    g = (gmax > 0) ? $urandom_range(0, gmax) : 0;
    if (g > 0) begin rx_valid = 0; rx_data = 8'($urandom); repeat (g) tick(); end
    rx_data = b; rx_valid = 1; ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin @(negedge clk); ok = rx_ready; tick(); end
    rx_valid = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_byte: byte %02h not accepted, rx_ready=%0b expected 1", b, rx_ready); end
  endtask

  task automatic send_image(input logic [31:0] hdr, input int gmax);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) send_byte(hdr[8*i +: 8], gmax);
    foreach (img_q[i]) begin
      w = img_q[i];
      for (int j = 0; j < BPW; j++) send_byte(w[8*j +: 8], gmax);
    end
  endtask

  // Returns one cycle into RUN, i.e. during the second RUN cycle
  task automatic wait_run();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = !core_reset; end
    tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_run: core_reset stayed 1, expected 0"); end
  endtask

  task automatic check_img(input string tag);
    chk({tag, "_wr_count"}, wr_q.size(), img_q.size());
    for (int i = 0; i < wr_q.size() && i < img_q.size(); i++) begin
      chk({tag, "_wr_addr"}, wr_q[i].a, i);
      chk({tag, "_wr_data"}, wr_q[i].d, img_q[i]);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hold, nw;
    do_reset();
    @(negedge clk);
    chk("lit_rst_rx_ready", rx_ready, 1);
    chk("lit_rst_core_reset", core_reset, 1);
    chk("lit_rst_words", words_loaded, 0);
    chk("lit_rst_we", imem_we, 0);
    tick();

    // Directed 2-word load, then halt sampled in the 5th RUN cycle
    img_q = '{32'h00500093, 32'h00100073};
    send_image(32'd2, 0);
    wait_run();
    chk("lit_load_words", words_loaded, 2);
    check_img("load");
    if (wr_q.size() == 2) chk("lit_crst_fall", fall_cyc, wr_q[1].c + 1);
    rx_valid = 1; rx_data = 8'hA5;
    tick(); tick(); tick();
    rx_valid = 0; core_halt = 1;
    tick();
    core_halt = 0;
    @(negedge clk);
    chk("lit_halt_done", done, 1);
    chk("lit_halt_crst", core_reset, 1);
    chk("lit_halt_count", cycle_count, 5);
    tick(); tick(); tick();
    @(negedge clk);
    chk("lit_halt_count_hold", cycle_count, 5);
    chk("lit_halt_words", wr_q.size(), 2);
    tick();

    // N=0: straight to RUN, then timeout
    do_reset(); img_q.delete();
    send_image(32'd0, 0);
    wait_run();
    repeat (20) tick();
    @(negedge clk);
    chk("lit_tmo_timeout", timeout, 1);
    chk("lit_tmo_count", cycle_count, 16);
    chk("lit_tmo_done", done, 0);
    chk("lit_tmo_nowrite", wr_q.size(), 0);
    tick();

    // Halt coinciding with the timeout cycle
    do_reset();
    send_image(32'd0, 0);
    wait_run();
    repeat (14) tick();
    core_halt = 1;
    tick();
    core_halt = 0;
    @(negedge clk);
    chk("lit_both_done", done, 1);
    chk("lit_both_timeout", timeout, 0);
    chk("lit_both_count", cycle_count, 16);
    tick();

    // N=17 exceeds a 16-word imem
    do_reset();
    send_image(32'd17, 0);
    rx_valid = 1; rx_data = 8'h13;
    repeat (4) tick();
    rx_valid = 0;
    @(negedge clk);
    chk("lit_err", err, 1);
    chk("lit_err_rx_ready", rx_ready, 0);
    chk("lit_err_crst", core_reset, 1);
    tick();

    // Same image with random gaps
    do_reset();
    img_q = '{32'h00500093, 32'h00100073};
    send_image(32'd2, 3);
    wait_run();
    check_img("gap");

    // Reset after 6 bytes, then full reload
    do_reset();
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h93, 0); send_byte(8'h00, 0);
    do_reset();
    send_image(32'd2, 1);
    wait_run();
    chk("lit_reload_words", words_loaded, 2);
    check_img("reload");

    // Randomized images, including the full 16-word boundary
    for (int it = 0; it < 6; it++) begin
      do_reset();
      nw = (it == 0) ? 16 : $urandom_range(1, 16);
      img_q.delete();
      for (int i = 0; i < nw; i++) img_q.push_back($urandom);
      send_image(32'(nw), 2);
      wait_run();
      check_img("rand");
      hold = $urandom_range(1, 20);
      for (int i = 0; i < hold; i++) begin
        rx_valid = 1'($urandom_range(0, 1)); rx_data = 8'($urandom); tick();
      end
      rx_valid = 0; core_halt = 1;
      tick();
      core_halt = 0;
      tick(); tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_boot_ctrl.md
Name: riscv_boot_ctrl

Overview:
- Synthesizable boot and run controller for the riscv core. It receives a program image as a byte stream and writes it word-by-word into imem, holding the core in reset while loading.
- After the load it releases the core, counts execution cycles and reports halt or timeout.
- Replaces file-based imem preloading. Memory depth, word width and timeout are parametrised.

Parameters:
- ADDR_W, 28, imem word-address width (same value as the riscv imem size parameter); legal range 1..31
- DATA_W, 32, instruction word width; must be a multiple of 8
- CNT_W, 32, width of cycle_count
- MAX_CYCLES, 1000000, run-cycle limit before timeout; must satisfy 1 ≤ MAX_CYCLES < 2**CNT_W

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  image byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  controller accepts a byte this cycle
- imem_we  out  1  imem write strobe, one-cycle pulse per word
- imem_addr  out  ADDR_W  imem word address
- imem_wdata  out  DATA_W  imem write data
- core_reset  out  1  reset to riscv core, active-high
- core_halt  in  1  core retired ebreak/ecall halt (level, sampled while in RUN)
- done  out  1  program halted normally (sticky)
- timeout  out  1  MAX_CYCLES reached without halt (sticky)
- err  out  1  bad image header (sticky)
- cycle_count  out  CNT_W  cycles spent in RUN
- words_loaded  out  ADDR_W+1  words written so far

Behaviour:
- Reset values:
  - rx_ready=1 and core_reset=1.
  - imem_we, imem_addr, imem_wdata, done, timeout, err, cycle_count and words_loaded are all 0.
  - State=HDR, byte index=0. imem contents are not touched.
- Byte transfer: a byte is accepted when rx_valid && rx_ready at the clock edge. Bytes are little-endian; byte k of a word fills bits [8k+7:8k]. The byte index wraps from DATA_W/8-1 to 0.
- States:
  - HDR: collect 4 bytes into 32-bit word count N.
    - On the 4th byte: N==0 goes to RUN; N > 2**ADDR_W goes to ERR; otherwise goes to LOAD with the word index set to 0.
  - LOAD: collect DATA_W/8 bytes per word.
    - The cycle after the last byte of a word: imem_we=1, imem_addr=word index, imem_wdata=assembled word, and words_loaded increments.
    - rx_ready stays 1 during the write cycle, so back-to-back bytes are accepted without stall.
    - After the write of word N-1 the controller goes to RUN.
  - RUN:
    - core_reset=0 from the first RUN cycle.
    - rx_ready=0; bytes offered are ignored.
    - cycle_count increments every RUN cycle.
    - core_halt=1 goes to HALT. Otherwise cycle_count == MAX_CYCLES-1 goes to TMO.
    - If both occur in the same cycle, HALT wins.
  - HALT: done=1, core_reset=1 (freezes core), cycle_count frozen. Terminal until reset.
  - TMO: timeout=1, core_reset=1, cycle_count frozen at MAX_CYCLES. Terminal until reset.
  - ERR: err=1, core_reset=1, rx_ready=0. Terminal until reset.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- core_reset is registered, with no glitch on state entry.
- Reset mid-load or mid-run: everything returns to its reset values on the next edge. Partial bytes are discarded and already-written imem words remain.
- rx_valid deasserted mid-word: the controller waits indefinitely; no timeout applies during HDR or LOAD.

Test Plan:
- Reset, then stream header N=2 followed by words 0x00500093 and 0x00100073 (bytes 02 00 00 00 93 00 50 00 73 00 10 00) with rx_valid held high:
  - imem_we pulses twice, at addr 0 then 1, with the correct data.
  - words_loaded=2.
  - core_reset falls exactly one cycle after the second write.
- From RUN, assert core_halt after 5 RUN cycles -> done=1, core_reset=1, cycle_count=5 and stays constant.
- MAX_CYCLES=16, core_halt held 0 -> timeout=1 and cycle_count=16 after 16 RUN cycles; core_halt and timeout coinciding -> done=1, timeout=0.
- Header N=0 -> RUN immediately with no imem_we pulse; ADDR_W=4 with header N=17 -> err=1, rx_ready=0, core_reset stays 1.
- Random rx_valid gaps inside words -> identical imem writes to the gapless case; bytes offered during RUN -> rx_ready=0, no writes.
- reset asserted after 6 bytes of a 2-word load, then the full image resent -> clean load from addr 0, words_loaded=2, no stray write.
